// File: rtl/win_rd_ctrl_if.sv
// win_rd_ctrl_if: address-in, DDR3 command/read-data and pixel-stream bundle.
// master = win_rd_ctrl side, slave = surrounding environment.
interface win_rd_ctrl_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] addr_in;
    logic              addr_in_valid;
    logic              addr_in_ready;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        input  addr_in, addr_in_valid, app_rdy, app_rd_data, app_rd_data_valid, pix_ready,
        output addr_in_ready, app_addr, app_cmd, app_en, pix_data, pix_valid, pix_last
    );

    modport slave (
        output addr_in, addr_in_valid, app_rdy, app_rd_data, app_rd_data_valid, pix_ready,
        input  addr_in_ready, app_addr, app_cmd, app_en, pix_data, pix_valid, pix_last
    );
endinterface

// File: rtl/win_rd_ctrl.sv
// win_rd_ctrl: issues single-word DDR3 reads for window points and streams the
// returned words in order, with credits bounding reads in flight to the FIFO depth.
// Optional macro WIN_RD_CTRL_RD_ERR_CHK_EN: tracks reads in flight and flags
// (and drops) read data that arrives with nothing outstanding.
module win_rd_ctrl #(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WIN_PTS = 9
) (
    input  logic          clk,
    input  logic          rst,
    win_rd_ctrl_if.master bus,
    output logic          busy,
    output logic          rd_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PT_W  = $clog2(WIN_PTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(WIN_PTS - 1);
    localparam logic [2:0]       CMD_READ = 3'b001;

    typedef enum logic [0:0] {IDLE, CMD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] app_addr_q, app_addr_nxt;
    logic              app_en_q, app_en_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [PT_W-1:0]   pt_q, pt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_nxt, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0]  fcnt_q, fcnt_nxt, fcnt_popped;
    logic [DATA_W-1:0] pix_data_q, pix_data_nxt;
    logic              pix_valid_q, pix_valid_nxt;
    logic              pix_last_q, pix_last_nxt;
    logic              busy_q, busy_nxt;
    logic              addr_ready_c, addr_fire, pix_fire, push;

    // Accept a new address when a credit is free and the command slot is (or becomes) free
    assign addr_ready_c = !rst && (cnt_q < CNT_MAX) && ((state == IDLE) || bus.app_rdy);
    assign addr_fire    = bus.addr_in_valid && addr_ready_c;
    assign pix_fire     = pix_valid_q && bus.pix_ready;

`ifdef WIN_RD_CTRL_RD_ERR_CHK_EN
    logic [CNT_W-1:0] infl_q, infl_nxt;
    logic             rd_err_q, rd_err_nxt;
    logic             stray;

    // In-flight tracking; data with nothing outstanding is dropped and flagged
    always_comb begin
        stray      = bus.app_rd_data_valid && (infl_q == '0);
        push       = bus.app_rd_data_valid && !stray;
        infl_nxt   = infl_q + CNT_W'(app_en_q && bus.app_rdy) - CNT_W'(push);
        rd_err_nxt = rd_err_q || stray;
    end

    // In-flight counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q   <= '0;
            rd_err_q <= 1'b0;
        end else begin
            infl_q   <= infl_nxt;
            rd_err_q <= rd_err_nxt;
        end
    end

    assign rd_err = rd_err_q;
`else
    assign push   = bus.app_rd_data_valid;
    assign rd_err = 1'b0;
`endif

    // Command FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command FSM next state and command address/enable
    always_comb begin
        state_nxt    = state;
        app_addr_nxt = app_addr_q;
        case (state)
            IDLE: begin
                if (addr_fire) begin
                    app_addr_nxt = bus.addr_in;
                    state_nxt    = CMD;
                end
            end
            CMD: begin
                if (bus.app_rdy) begin
                    if (addr_fire) begin
                        app_addr_nxt = bus.addr_in;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        app_en_nxt = (state_nxt == CMD);
    end

    // Credits, window point, FIFO pointers and the registered FIFO head
    always_comb begin
        cnt_nxt = cnt_q;
        if (addr_fire && !pix_fire) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else if (!addr_fire && pix_fire) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end

        pt_nxt = pt_q;
        if (pix_fire) begin
            pt_nxt = (pt_q == PT_LAST) ? '0 : pt_q + PT_W'(1);
        end

        rd_ptr_nxt  = pix_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_nxt  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        fcnt_popped = fcnt_q - CNT_W'(pix_fire);
        fcnt_nxt    = fcnt_popped + CNT_W'(push);

        // Head bypasses the array when the incoming word lands in an empty FIFO
        pix_data_nxt = pix_data_q;
        if (push && (fcnt_popped == '0)) begin
            pix_data_nxt = bus.app_rd_data;
        end else if (fcnt_popped != '0) begin
            pix_data_nxt = mem[rd_ptr_nxt];
        end

        pix_valid_nxt = (fcnt_nxt != '0);
        pix_last_nxt  = pix_valid_nxt && (pt_nxt == PT_LAST);
        busy_nxt      = (cnt_nxt != '0) || (state_nxt == CMD);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_addr_q  <= '0;
            app_en_q    <= 1'b0;
            cnt_q       <= '0;
            pt_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            app_addr_q  <= app_addr_nxt;
            app_en_q    <= app_en_nxt;
            cnt_q       <= cnt_nxt;
            pt_q        <= pt_nxt;
            wr_ptr_q    <= wr_ptr_nxt;
            rd_ptr_q    <= rd_ptr_nxt;
            fcnt_q      <= fcnt_nxt;
            pix_data_q  <= pix_data_nxt;
            pix_valid_q <= pix_valid_nxt;
            pix_last_q  <= pix_last_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // FIFO storage; credits keep writes away from a full FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.app_rd_data;
        end
    end

    assign bus.addr_in_ready = addr_ready_c;
    assign bus.app_addr      = app_addr_q;
    assign bus.app_cmd       = CMD_READ;
    assign bus.app_en        = app_en_q;
    assign bus.pix_data      = pix_data_q;
    assign bus.pix_valid     = pix_valid_q;
    assign bus.pix_last      = pix_last_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_win_rd_ctrl.sv
// tb_win_rd_ctrl: scoreboard bench with a fixed-latency DDR3 read model.
module tb_win_rd_ctrl;
    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned WIN_PTS = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, rd_err;

    win_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    win_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WIN_PTS(WIN_PTS)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .rd_err (rd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_lat = 5;
    int win_idx, acc_total, pops, en_cycles;
    int acc_cyc, en_first_cyc, pix_first_cyc, ret_cyc;
    bit en_seen, pix_seen, acc, ret_now;

    logic [ADDR_W-1:0] cmd_q[$];
    logic [32:0]       exp_q[$];
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [ADDR_W-1:0] a);
        if (a == 28'h0000040) return 32'hDEADBEEF;
        return {4'h0, a};
    endfunction

    // One clock: observe handshakes before the edge, drive DDR3 return data after it
    task automatic step();
        logic [32:0]       e;
        logic [ADDR_W-1:0] a;
        int                d;
        @(negedge clk);
        acc = 1'b0;
        if (bus.app_en) begin
            en_cycles++;
            if (!en_seen) begin en_seen = 1'b1; en_first_cyc = cyc; end
        end
        if (bus.app_en && bus.app_rdy) begin
            if (cmd_q.size() == 0) begin
                check("app_en_unexpected", 32'(bus.app_en), 32'd0);
            end else begin
                a = cmd_q.pop_front();
                check("app_addr", 32'(bus.app_addr), 32'(a));
                check("app_cmd", 32'(bus.app_cmd), 32'd1);
            end
            pend_addr.push_back(bus.app_addr);
            pend_due.push_back(cyc + rd_lat);
        end
        if (bus.addr_in_valid && bus.addr_in_ready) begin
            acc = 1'b1;
            acc_total++;
            acc_cyc = cyc;
            cmd_q.push_back(bus.addr_in);
            exp_q.push_back({(win_idx == int'(WIN_PTS) - 1), data_of(bus.addr_in)});
            win_idx = (win_idx == int'(WIN_PTS) - 1) ? 0 : win_idx + 1;
        end
        if (bus.pix_valid && !pix_seen) begin
            pix_seen = 1'b1;
            pix_first_cyc = cyc;
        end
        if (bus.pix_valid && bus.pix_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("pix_valid_unexpected", 32'(bus.pix_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", 32'(bus.pix_data), e[31:0]);
                check("pix_last", 32'(bus.pix_last), 32'(e[32]));
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        ret_now = 1'b0;
        bus.app_rd_data_valid = 1'b0;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            d = pend_due.pop_front();
            a = pend_addr.pop_front();
            bus.app_rd_data = data_of(a);
            bus.app_rd_data_valid = 1'b1;
            ret_now = 1'b1;
            ret_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        bus.addr_in_valid = 1'b1;
        bus.addr_in = '0;
        bus.app_rdy = 1'b0;
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data = '0;
        bus.pix_ready = 1'b0;
        rst = 1'b1;
        cmd_q.delete(); exp_q.delete(); pend_addr.delete(); pend_due.delete();
        win_idx = 0; acc_total = 0; pops = 0; en_cycles = 0;
        en_seen = 1'b0; pix_seen = 1'b0; acc = 1'b0; ret_now = 1'b0;
        @(posedge clk); cyc++;
        @(negedge clk);
        check("rst_addr_in_ready", 32'(bus.addr_in_ready), 32'd0);
        check("rst_app_en", 32'(bus.app_en), 32'd0);
        check("rst_app_addr", 32'(bus.app_addr), 32'd0);
        check("rst_app_cmd", 32'(bus.app_cmd), 32'd1);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_last", 32'(bus.pix_last), 32'd0);
        check("rst_pix_data", 32'(bus.pix_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        @(posedge clk); cyc++;
        #1;
        bus.addr_in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.addr_in_valid = 1'b0;
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && pend_due.size() == 0 && cmd_q.size() == 0) break;
            step();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_acc, last_acc;
        bit done;
        logic [ADDR_W-1:0] nxt;

        // Single read
        do_reset();
        bus.app_rdy = 1'b1;
        bus.pix_ready = 1'b1;
        bus.addr_in = 28'h0000040;
        bus.addr_in_valid = 1'b1;
        for (int i = 0; i < 10 && acc_total == 0; i++) step();
        bus.addr_in_valid = 1'b0;
        check("single_busy_on", 32'(busy), 32'd1);
        drain();
        check("single_en_cycles", 32'(en_cycles), 32'd1);
        check("single_cmd_lat", 32'(en_first_cyc), 32'(acc_cyc + 1));
        check("single_pix_lat", 32'(pix_first_cyc), 32'(ret_cyc + 1));
        check("single_busy_off", 32'(busy), 32'd0);

        // Full window, back-to-back
        do_reset();
        bus.app_rdy = 1'b1;
        bus.pix_ready = 1'b1;
        nxt = 28'd1;
        bus.addr_in = nxt;
        bus.addr_in_valid = 1'b1;
        first_acc = -1; last_acc = -1;
        for (int i = 0; i < 50 && bus.addr_in_valid; i++) begin
            step();
            if (acc) begin
                if (first_acc < 0) first_acc = acc_cyc;
                last_acc = acc_cyc;
                if (nxt == 28'd9) bus.addr_in_valid = 1'b0;
                else begin nxt = nxt + 28'd1; bus.addr_in = nxt; end
            end
        end
        drain();
        check("win_accepts", 32'(acc_total), 32'd9);
        check("win_accept_span", 32'(last_acc - first_acc), 32'd8);
        check("win_en_cycles", 32'(en_cycles), 32'd9);
        check("win_pops", 32'(pops), 32'd9);

        // Credit stall
        do_reset();
        bus.app_rdy = 1'b1;
        bus.pix_ready = 1'b0;
        nxt = 28'h100;
        bus.addr_in = nxt;
        bus.addr_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc) begin nxt = nxt + 28'd1; bus.addr_in = nxt; end
        end
        check("credit_accepts", 32'(acc_total), 32'd8);
        check("credit_ready_low", 32'(bus.addr_in_ready), 32'd0);
        bus.pix_ready = 1'b1;
        step();
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc) begin nxt = nxt + 28'd1; bus.addr_in = nxt; end
        end
        check("credit_one_more", 32'(acc_total), 32'd9);
        drain();
        check("credit_pops", 32'(pops), 32'd9);

        // app_rdy backpressure
        do_reset();
        bus.app_rdy = 1'b0;
        bus.pix_ready = 1'b1;
        bus.addr_in = 28'h200;
        bus.addr_in_valid = 1'b1;
        step();
        bus.addr_in = 28'h201;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_app_en", 32'(bus.app_en), 32'd1);
            check("bp_app_addr", 32'(bus.app_addr), 32'h200);
            check("bp_ready", 32'(bus.addr_in_ready), 32'd0);
        end
        bus.app_rdy = 1'b1;
        step();
        bus.addr_in_valid = 1'b0;
        drain();
        check("bp_accepts", 32'(acc_total), 32'd2);
        check("bp_pops", 32'(pops), 32'd2);

        // FIFO full, then push and pop in the same cycle
        do_reset();
        bus.app_rdy = 1'b1;
        bus.pix_ready = 1'b0;
        nxt = 28'h300;
        bus.addr_in = nxt;
        bus.addr_in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (acc) begin nxt = nxt + 28'd1; bus.addr_in = nxt; end
        end
        check("full_accepts", 32'(acc_total), 32'd8);
        check("full_ready_low", 32'(bus.addr_in_ready), 32'd0);
        check("full_pix_valid", 32'(bus.pix_valid), 32'd1);
        check("full_head_hold", 32'(bus.pix_data), exp_q[0][31:0]);
        bus.pix_ready = 1'b1;
        step();
        bus.pix_ready = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (acc) bus.addr_in_valid = 1'b0;
            if (ret_now) begin
                bus.pix_ready = 1'b1;
                step();
                bus.pix_ready = 1'b0;
                check("full_swap_valid", 32'(bus.pix_valid), 32'd1);
                done = 1'b1;
            end
        end
        check("full_swap_seen", 32'(done), 32'd1);
        drain();
        check("full_pops", 32'(pops), 32'd9);

        // Reset asserted mid-operation
        do_reset();
        bus.app_rdy = 1'b1;
        bus.pix_ready = 1'b1;
        nxt = 28'h400;
        bus.addr_in = nxt;
        bus.addr_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (acc) begin nxt = nxt + 28'd1; bus.addr_in = nxt; end
        end
        rst = 1'b1;
        #1;
        check("midrst_app_en", 32'(bus.app_en), 32'd0);
        check("midrst_app_addr", 32'(bus.app_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(bus.addr_in_ready), 32'd0);
        check("midrst_pix_valid", 32'(bus.pix_valid), 32'd0);

`ifdef WIN_RD_CTRL_RD_ERR_CHK_EN
        // Stray read data with nothing in flight
        do_reset();
        bus.pix_ready = 1'b1;
        step();
        bus.app_rd_data = 32'h12345678;
        bus.app_rd_data_valid = 1'b1;
        step();
        check("err_set", 32'(rd_err), 32'd1);
        check("err_fifo_empty", 32'(bus.pix_valid), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("err_sticky", 32'(rd_err), 32'd1);
        do_reset();
        check("err_cleared", 32'(rd_err), 32'd0);
`else
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check("rd_err_tied", 32'(rd_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
